// File: rtl/imem_code_loader.sv
// Byte-stream code loader for the instruction memory port B: packs bytes big-endian into
// 32-bit words, writes them at consecutive word addresses and optionally reads each one back.
module imem_code_loader #(
  parameter int         PC_BITWIDTH = 16,
  parameter int         RD_LATENCY  = 2,
  parameter logic [7:0] PAD_BYTE    = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PC_BITWIDTH-3:0] base_addr,
  input  logic [PC_BITWIDTH-1:0] byte_count,
  input  logic                   verify_en,
  input  logic [7:0]             s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   mem_we,
  output logic [PC_BITWIDTH-3:0] mem_wr_addr,
  output logic [31:0]            mem_data_out,
  output logic                   mem_re_B,
  output logic [PC_BITWIDTH-1:0] mem_re_addr_B,
  input  logic [31:0]            mem_rd_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [PC_BITWIDTH-3:0] err_word_addr
);

  localparam int WAW = PC_BITWIDTH - 2;
  localparam int CW  = PC_BITWIDTH + 1;
  localparam int LW  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_VERIFY,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    word_q, word_d;
  logic [1:0]     lane_q, lane_d;
  logic [CW-1:0]  remain_q, remain_d;
  logic [WAW-1:0] addr_q, addr_d;
  logic           verify_q, verify_d;
  logic [LW-1:0]  lat_q, lat_d;
  logic           error_q, error_d;
  logic [WAW-1:0] err_addr_q, err_addr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      lane_q     <= '0;
      remain_q   <= '0;
      addr_q     <= '0;
      verify_q   <= 1'b0;
      lat_q      <= '0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      lane_q     <= lane_d;
      remain_q   <= remain_d;
      addr_q     <= addr_d;
      verify_q   <= verify_d;
      lat_q      <= lat_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    lane_d     = lane_q;
    remain_d   = remain_q;
    addr_d     = addr_q;
    verify_d   = verify_q;
    lat_d      = lat_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    s_ready    = 1'b0;
    mem_we     = 1'b0;
    mem_re_B   = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          remain_d   = {1'b0, byte_count};
          verify_d   = verify_en;
          error_d    = 1'b0;
          err_addr_d = '0;
          word_d     = {4{PAD_BYTE}};
          lane_d     = '0;
          state_d    = (byte_count == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          // lane 0 is the most significant byte: bit offset is 8*(3-lane)
          word_d[{~lane_q, 3'b000} +: 8] = s_data;
          lane_d   = lane_q + 2'd1;
          remain_d = remain_q - CW'(1);
          if (lane_q == 2'd3 || remain_q == CW'(1)) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        mem_we  = 1'b1;
        state_d = verify_q ? S_VERIFY : S_NEXT;
      end
      S_VERIFY: begin
        mem_re_B = 1'b1;
        lat_d    = LW'(RD_LATENCY - 1);
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          if (mem_rd_data != word_q) begin
            error_d = 1'b1;
            if (!error_q) begin
              err_addr_d = addr_q;
            end
          end
          state_d = S_NEXT;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_NEXT: begin
        addr_d  = addr_q + WAW'(1);
        word_d  = {4{PAD_BYTE}};
        lane_d  = '0;
        state_d = (remain_q == '0) ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign mem_wr_addr   = addr_q;
  assign mem_data_out  = word_q;
  assign mem_re_addr_B = {addr_q, 2'b00};
  assign error         = error_q;
  assign err_word_addr = err_addr_q;

endmodule

// File: tb/tb_imem_code_loader.sv
// Bench for imem_code_loader: table-driven scenarios, an abort-by-reset sequence and random loads
// checked against a word-packing reference model with a latency-accurate port-B memory.
module tb_imem_code_loader;

  localparam int         PCW = 16;
  localparam int         WAW = PCW - 2;
  localparam int         RDL = 2;
  localparam logic [7:0] PAD = 8'h00;

  logic           clk, reset, start, verify_en, s_valid, s_ready;
  logic           mem_we, mem_re_B, busy, done, error;
  logic [WAW-1:0] base_addr, mem_wr_addr, err_word_addr;
  logic [PCW-1:0] byte_count, mem_re_addr_B;
  logic [7:0]     s_data;
  logic [31:0]    mem_data_out, mem_rd_data;

  typedef struct {
    logic [WAW-1:0] addr;
    logic [31:0]    data;
  } wr_t;

  typedef struct {
    logic [WAW-1:0] base;
    int             count;
    bit             verify;
    int             corrupt_mask;
    int             valid_pct;
    logic [7:0]     first_byte;
    logic [7:0]     step;
    int             exp_writes;
    bit             exp_error;
    logic [WAW-1:0] exp_err_addr;
    logic [31:0]    exp_w0;
    logic [WAW-1:0] exp_last_addr;
    logic [31:0]    exp_last_data;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          overlap_cnt = 0;
  logic [31:0] mem     [0:(1<<WAW)-1];
  bit          corrupt [0:(1<<WAW)-1];
  logic [31:0] rd_pipe [RDL];
  wr_t         obs_q[$];
  wr_t         exp_q[$];
  logic [7:0]  src[$];
  bit          m_err;
  logic [WAW-1:0] m_err_addr;
  vec_t        vecs[5];

  imem_code_loader #(
    .PC_BITWIDTH(PCW),
    .RD_LATENCY (RDL),
    .PAD_BYTE   (PAD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .byte_count   (byte_count),
    .verify_en    (verify_en),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .mem_we       (mem_we),
    .mem_wr_addr  (mem_wr_addr),
    .mem_data_out (mem_data_out),
    .mem_re_B     (mem_re_B),
    .mem_re_addr_B(mem_re_addr_B),
    .mem_rd_data  (mem_rd_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_word_addr(err_word_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  function automatic logic [31:0] rd_word(input logic [PCW-1:0] a);
    logic [31:0] v;
    v = mem[a[PCW-1:2]];
    if (corrupt[a[PCW-1:2]]) v = v ^ 32'h0000_0100;
    return v;
  endfunction

  // port-B memory: write on strobe, read data appears RDL cycles after the read request
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wr_addr] <= mem_data_out;
      obs_q.push_back('{mem_wr_addr, mem_data_out});
    end
    rd_pipe[0] <= mem_re_B ? rd_word(mem_re_addr_B) : 32'h0;
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rd_data = rd_pipe[RDL-1];

  always @(negedge clk) if (mem_we && mem_re_B) overlap_cnt <= overlap_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setup_corrupt(input logic [WAW-1:0] base, input int n, input int mask);
    for (int i = 0; i < (1 << WAW); i++) corrupt[i] = 1'b0;
    for (int i = 0; i < (n + 3) / 4; i++)
      if (mask[i]) corrupt[WAW'(int'(base) + i)] = 1'b1;
  endtask

  task automatic build_model(input logic [WAW-1:0] base, input int n, input bit verify);
    logic [31:0]    w;
    logic [WAW-1:0] a;
    exp_q.delete();
    m_err      = 1'b0;
    m_err_addr = '0;
    for (int i = 0; i < (n + 3) / 4; i++) begin
      w = {4{PAD}};
      for (int b = 0; b < 4; b++)
        if (4 * i + b < n) w[31 - 8 * b -: 8] = src[4 * i + b];
      a = WAW'(int'(base) + i);
      exp_q.push_back('{a, w});
      if (verify && corrupt[a] && !m_err) begin
        m_err      = 1'b1;
        m_err_addr = a;
      end
    end
  endtask

  task automatic run_load(input logic [WAW-1:0] base, input int n, input bit verify,
                          input int pct, input int abort_at, output bit aborted);
    int idx, cyc;
    bit got_done, exp_we, exp_re, chk_re;
    aborted  = 1'b0;
    got_done = 1'b0;
    exp_we   = 1'b0;
    exp_re   = 1'b0;
    idx      = 0;
    cyc      = 0;
    @(negedge clk);
    start      = 1'b1;
    base_addr  = base;
    byte_count = PCW'(n);
    verify_en  = verify;
    s_valid    = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!got_done && !aborted && cyc < 3000) begin
      chk_re = exp_re;
      exp_re = 1'b0;
      if (chk_re) check("re_after_we", 32'(mem_re_B), 32'd1);
      if (exp_we) begin
        check("we_latency", 32'(mem_we), 32'd1);
        exp_re = verify;
        exp_we = 1'b0;
      end
      if (done) begin
        check("busy_at_done", 32'(busy), 32'd1);
        got_done = 1'b1;
        start    = 1'b0;
        s_valid  = 1'b0;
      end else if (abort_at >= 0 && idx == abort_at) begin
        aborted = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
      end else begin
        // starts while busy must be ignored, along with whatever rides on them
        start      = ($urandom_range(7) == 0);
        base_addr  = WAW'($urandom);
        byte_count = PCW'($urandom);
        verify_en  = $urandom_range(1) == 1;
        if (idx < n) begin
          s_valid = ($urandom_range(99) < pct);
          s_data  = s_valid ? src[idx] : 8'($urandom);
        end else begin
          s_valid = 1'b0;
        end
        if (s_valid && s_ready) begin
          if (idx % 4 == 3 || idx == n - 1) exp_we = 1'b1;
          idx++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (abort_at < 0) begin
      check("done_seen", 32'(got_done), 32'd1);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic compare_model(input int id);
    check($sformatf("ld%0d_nwrites", id), 32'(obs_q.size()), 32'(exp_q.size()));
    if (obs_q.size() == exp_q.size()) begin
      foreach (exp_q[i]) begin
        check($sformatf("ld%0d_waddr%0d", id, i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
        check($sformatf("ld%0d_wdata%0d", id, i), obs_q[i].data, exp_q[i].data);
      end
    end
    check($sformatf("ld%0d_error", id), 32'(error), 32'(m_err));
    if (m_err) check($sformatf("ld%0d_err_addr", id), 32'(err_word_addr), 32'(m_err_addr));
  endtask

  task automatic full_load(input int id, input logic [WAW-1:0] base, input int n,
                           input bit verify, input int mask, input int pct);
    bit ab;
    setup_corrupt(base, n, mask);
    build_model(base, n, verify);
    obs_q.delete();
    run_load(base, n, verify, pct, -1, ab);
    compare_model(id);
  endtask

  initial begin
    bit ab;
    reset = 1'b1; start = 1'b0; base_addr = '0; byte_count = '0;
    verify_en = 1'b0; s_data = '0; s_valid = 1'b0;
    for (int i = 0; i < RDL; i++) rd_pipe[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re_B), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_err_addr", 32'(err_word_addr), 32'd0);
    check("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
    check("rst_wr_data", mem_data_out, 32'd0);
    check("rst_re_addr", 32'(mem_re_addr_B), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    //             base      cnt ver mask pct  b0     step  nw err erraddr   w0            last_addr last_data
    vecs[0] = '{14'h0010,  8, 0, 0,     100, 8'h11, 8'h11, 2, 0, 14'h0000, 32'h11223344, 14'h0011, 32'h55667788};
    vecs[1] = '{14'h0123,  5, 0, 0,     100, 8'hA1, 8'h01, 2, 0, 14'h0000, 32'hA1A2A3A4, 14'h0124, 32'hA5000000};
    vecs[2] = '{14'h0200,  0, 0, 0,     100, 8'h00, 8'h00, 0, 0, 14'h0000, 32'h0,        14'h0000, 32'h0};
    vecs[3] = '{14'h0040, 12, 1, 3'b110, 100, 8'h30, 8'h07, 3, 1, 14'h0041, 32'h30373E45, 14'h0042, 32'h686F767D};
    vecs[4] = '{14'h3FFF,  8, 1, 0,      50, 8'hC0, 8'h03, 2, 0, 14'h0000, 32'hC0C3C6C9, 14'h0000, 32'hCCCFD2D5};

    for (int v = 0; v < 5; v++) begin
      src.delete();
      for (int k = 0; k < vecs[v].count; k++)
        src.push_back(8'(int'(vecs[v].first_byte) + k * int'(vecs[v].step)));
      full_load(v, vecs[v].base, vecs[v].count, vecs[v].verify, vecs[v].corrupt_mask,
                vecs[v].valid_pct);
      check($sformatf("vec%0d_nwrites", v), 32'(obs_q.size()), 32'(vecs[v].exp_writes));
      check($sformatf("vec%0d_error", v), 32'(error), 32'(vecs[v].exp_error));
      if (vecs[v].exp_error)
        check($sformatf("vec%0d_err_addr", v), 32'(err_word_addr), 32'(vecs[v].exp_err_addr));
      if (vecs[v].exp_writes > 0 && obs_q.size() == vecs[v].exp_writes) begin
        check($sformatf("vec%0d_w0", v), obs_q[0].data, vecs[v].exp_w0);
        check($sformatf("vec%0d_last_addr", v), 32'(obs_q[$].addr), 32'(vecs[v].exp_last_addr));
        check($sformatf("vec%0d_last_data", v), obs_q[$].data, vecs[v].exp_last_data);
      end
    end

    // reset after 6 of 12 bytes, with word 0 already flagged as a verify mismatch
    src.delete();
    for (int k = 0; k < 12; k++) src.push_back(8'($urandom));
    setup_corrupt(14'h0080, 12, 1);
    build_model(14'h0080, 12, 1'b1);
    obs_q.delete();
    run_load(14'h0080, 12, 1'b1, 100, 6, ab);
    check("abort_reached", 32'(ab), 32'd1);
    check("abort_pre_error", 32'(error), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_s_ready", 32'(s_ready), 32'd0);
    check("abort_error", 32'(error), 32'd0);
    check("abort_wr_data", mem_data_out, 32'd0);
    check("abort_wr_addr", 32'(mem_wr_addr), 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_nwrites", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() == 1) check("abort_w0", obs_q[0].data, exp_q[0].data);
    src.delete();
    for (int k = 0; k < 9; k++) src.push_back(8'($urandom));
    full_load(10, 14'h0081, 9, 1'b1, 0, 80);

    for (int r = 0; r < 20; r++) begin
      int n;
      n = $urandom_range(22);
      src.delete();
      for (int k = 0; k < n; k++) src.push_back(8'($urandom));
      full_load(100 + r, WAW'($urandom), n, $urandom_range(1) == 1, int'($urandom_range(63)),
                int'($urandom_range(100, 30)));
    end

    check("we_re_overlap", 32'(overlap_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
